// File: rtl/reference_index_sequencer_pkg.sv
// Shared types and default geometry for the reference sample buffer and its
// index sequencer.
package reference_index_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_BUFFER_LENGTH = 10;
    localparam int DEF_BUFFER_BITS   = 4;

endpackage

// File: rtl/reference_index_sequencer_mod.sv
// Modulo-length counter: load (out-of-range values load as 0), increment, and
// wrap from buffer_length-1 back to 0.
module mod_counter #(
    parameter int buffer_length = 10,
    parameter int buffer_bits   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [buffer_bits-1:0] load_value,
    input  logic                   inc,
    output logic [buffer_bits-1:0] count,
    output logic                   at_last
);

    localparam logic [buffer_bits-1:0] last_idx = buffer_bits'(buffer_length - 1);
    localparam logic [buffer_bits-1:0] one      = buffer_bits'(1);

    logic [buffer_bits-1:0] count_q, count_d;

    assign at_last = (count_q == last_idx);
    assign count   = count_q;

    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (load) begin
            count_d = (load_value > last_idx) ? '0 : load_value;
        end else if (inc) begin
            count_d = at_last ? '0 : count_q + one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state flops use non-blocking assignments so all registers update together.
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

endmodule

// File: rtl/reference_index_sequencer.sv
// Plays out num_passes full sweeps of the reference buffer address space, each
// pass starting one index later than the previous (modulo buffer_length).
module reference_index_sequencer
    import reference_index_sequencer_pkg::*;
#(
    parameter int buffer_length = DEF_BUFFER_LENGTH,
    parameter int buffer_bits   = DEF_BUFFER_BITS,
    parameter int pass_bits     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [buffer_bits-1:0] start_offset,
    input  logic [pass_bits-1:0]   num_passes,
    input  logic                   m_axis_index_tready,
    output logic                   m_axis_index_tvalid,
    output logic [buffer_bits-1:0] m_axis_index_tdata,
    output logic                   m_axis_index_tlast,
    output logic [pass_bits-1:0]   pass_index,
    output logic                   busy,
    output logic                   done
);

    localparam logic [buffer_bits-1:0] last_idx = buffer_bits'(buffer_length - 1);
    localparam logic [buffer_bits-1:0] one_b    = buffer_bits'(1);
    localparam logic [pass_bits-1:0]   one_p    = pass_bits'(1);

    state_e                 state_q, state_d;
    logic [pass_bits-1:0]   passes_q, passes_d;
    logic [pass_bits-1:0]   pass_index_q, pass_index_d;
    logic [buffer_bits-1:0] beat, base, room;
    logic                   beat_last, base_last;
    logic                   beat_load, beat_inc, base_load, base_inc;
    logic                   accept, final_pass, running;

    mod_counter #(.buffer_length(buffer_length), .buffer_bits(buffer_bits)) u_beat (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (beat_load),
        .load_value ('0),
        .inc        (beat_inc),
        .count      (beat),
        .at_last    (beat_last)
    );

    mod_counter #(.buffer_length(buffer_length), .buffer_bits(buffer_bits)) u_base (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (base_load),
        .load_value (start_offset),
        .inc        (base_inc),
        .count      (base),
        .at_last    (base_last)
    );

    assign running    = (state_q == RUN);
    assign accept     = running && m_axis_index_tready;
    assign final_pass = (pass_index_q == (passes_q - one_p));

    always_comb begin
        state_d      = state_q;
        passes_d     = passes_q;
        pass_index_d = pass_index_q;
        beat_load    = 1'b0;
        beat_inc     = 1'b0;
        base_load    = 1'b0;
        base_inc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_passes != '0) begin
                        state_d      = RUN;
                        passes_d     = num_passes;
                        pass_index_d = '0;
                        beat_load    = 1'b1;
                        base_load    = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    beat_inc = 1'b1;
                    if (beat_last) begin
                        if (final_pass) begin
                            state_d = DONE;
                        end else begin
                            pass_index_d = pass_index_q + one_p;
                            base_inc     = 1'b1;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            passes_q     <= '0;
            pass_index_q <= '0;
        end else begin
            state_q      <= state_d;
            passes_q     <= passes_d;
            pass_index_q <= pass_index_d;
        end
    end

    // Both base and beat are < buffer_length, so (base+beat) mod length needs at
    // most one subtraction; room is how far base can advance before wrapping.
    assign room = last_idx - base;

    assign m_axis_index_tvalid = running;
    assign m_axis_index_tdata  = !running      ? '0 :
                                 (beat > room) ? (beat - room - one_b) :
                                                 (base + beat);
    assign m_axis_index_tlast  = running && beat_last;
    assign pass_index          = pass_index_q;
    assign busy                = (state_q != IDLE);
    assign done                = (state_q == DONE);

endmodule

// File: tb/tb_reference_index_sequencer.sv
// Directed scenarios for reference_index_sequencer; expected beats are queued
// when a sequence is started and popped as the DUT hands them over.
module tb_reference_index_sequencer;

    localparam int L  = 10;
    localparam int BB = 4;
    localparam int PB = 8;

    typedef struct {
        int data;
        int last;
        int pidx;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [BB-1:0] start_offset = '0;
    logic [PB-1:0] num_passes = '0;
    logic          tready = 1'b0;
    logic          tvalid;
    logic [BB-1:0] tdata;
    logic          tlast;
    logic [PB-1:0] pass_index;
    logic          busy;
    logic          done;

    int tests  = 0;
    int fails  = 0;
    beat_t exp_q[$];

    reference_index_sequencer #(.buffer_length(L), .buffer_bits(BB), .pass_bits(PB)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .start_offset        (start_offset),
        .num_passes          (num_passes),
        .m_axis_index_tready (tready),
        .m_axis_index_tvalid (tvalid),
        .m_axis_index_tdata  (tdata),
        .m_axis_index_tlast  (tlast),
        .pass_index          (pass_index),
        .busy                (busy),
        .done                (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: tready always high; mode 1: 3-cycle stall at beat 5, odd cycles low.
    // busy_at >= 0 pulses a conflicting start when that many beats are accepted.
    // rst_at  >= 0 aborts with an asynchronous reset after that many beats.
    task automatic run_seq(input int offset, input int passes, input int mode,
                           input int busy_at, input int rst_at);
        int    eff, accepted, cyc, stall, prev_stall;
        int    held_data, held_last, held_pidx;
        beat_t b;
        eff = (offset >= L) ? 0 : offset;
        for (int p = 0; p < passes; p++)
            for (int k = 0; k < L; k++) begin
                b.data = ((eff + p) % L + k) % L;
                b.last = (k == L - 1) ? 1 : 0;
                b.pidx = p;
                exp_q.push_back(b);
            end
        start        = 1'b1;
        start_offset = BB'(offset);
        num_passes   = PB'(passes);
        tready       = 1'b0;
        step();
        start = 1'b0;
        start_offset = BB'($urandom_range(0, 15));
        num_passes   = PB'($urandom_range(0, 255));
        accepted = 0; cyc = 0; stall = 0; prev_stall = 0;
        held_data = 0; held_last = 0; held_pidx = 0;
        while (exp_q.size() > 0) begin
            if (rst_at >= 0 && accepted == rst_at) begin
                #1 rst_n = 1'b0;
                #1;
                check("rst_tvalid", int'(tvalid), 0);
                check("rst_tdata",  int'(tdata), 0);
                check("rst_tlast",  int'(tlast), 0);
                check("rst_pidx",   int'(pass_index), 0);
                check("rst_busy",   int'(busy), 0);
                check("rst_done",   int'(done), 0);
                exp_q.delete();
                step();
                check("rst_hold_done", int'(done), 0);
                #2 rst_n = 1'b1;
                step();
                return;
            end
            if (cyc > 5 * passes * L + 20) begin
                check("timeout", 1, 0);
                exp_q.delete();
                break;
            end
            start = (busy_at >= 0 && accepted == busy_at) ? 1'b1 : 1'b0;
            if (start) begin
                start_offset = BB'(7);
                num_passes   = PB'(3);
            end
            if (mode == 0) tready = 1'b1;
            else if (accepted == 4 && stall < 3) begin
                tready = 1'b0;
                stall++;
            end else tready = (cyc % 2 == 0);
            check("tvalid_high", int'(tvalid), 1);
            check("busy_run", int'(busy), 1);
            if (prev_stall != 0) begin
                check("hold_tdata", int'(tdata), held_data);
                check("hold_tlast", int'(tlast), held_last);
                check("hold_pidx",  int'(pass_index), held_pidx);
            end
            if (tvalid && tready) begin
                b = exp_q.pop_front();
                check("tdata", int'(tdata), b.data);
                check("tlast", int'(tlast), b.last);
                check("pass_index", int'(pass_index), b.pidx);
                accepted++;
                prev_stall = 0;
            end else begin
                held_data = int'(tdata);
                held_last = int'(tlast);
                held_pidx = int'(pass_index);
                prev_stall = 1;
            end
            cyc++;
            step();
        end
        start  = 1'b0;
        tready = 1'b0;
        check("accepted_total", accepted, passes * L);
        check("done_pulse", int'(done), 1);
        check("done_busy", int'(busy), 1);
        check("done_tvalid", int'(tvalid), 0);
        step();
        check("done_cleared", int'(done), 0);
        check("idle_busy", int'(busy), 0);
    endtask

    initial begin
        #2;
        check("reset_tvalid", int'(tvalid), 0);
        check("reset_tdata",  int'(tdata), 0);
        check("reset_tlast",  int'(tlast), 0);
        check("reset_pidx",   int'(pass_index), 0);
        check("reset_busy",   int'(busy), 0);
        check("reset_done",   int'(done), 0);
        #10 rst_n = 1'b1;
        step();

        run_seq(3, 1, 0, -1, -1);   // single pass
        run_seq(9, 2, 0, -1, -1);   // base wraps between passes
        run_seq(3, 1, 1, -1, -1);   // backpressure, same sequence
        run_seq(9, 2, 1, -1, -1);
        run_seq(0, 0, 0, -1, -1);   // zero passes
        run_seq(12, 1, 0, -1, -1);  // out-of-range offset
        run_seq(4, 2, 0, 5, -1);    // start while busy is ignored
        run_seq(2, 1, 0, -1, 6);    // reset mid-run
        run_seq(5, 1, 0, -1, -1);   // clean run after reset
        // Back-to-back: start accepted in the cycle after done.
        run_seq(8, 3, 0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
